// File: rtl/reg_file_dump_if.sv
// Bundles the register-file read/snoop port, the dump control and the output word stream.
// Latency: none; wires only.
// Backpressure: OutValid/OutReady handshake on the output stream.
interface reg_file_dump_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              Start;
   logic [ADDR_W-1:0] StartAddr;
   logic [5:0]        Count;
   logic [ADDR_W-1:0] RdAddr;
   logic [DATA_W-1:0] RdData;
   logic              WrEn;
   logic [ADDR_W-1:0] WrAddr;
   logic [DATA_W-1:0] WrData;
   logic              OutValid;
   logic              OutReady;
   logic [ADDR_W-1:0] OutAddr;
   logic [DATA_W-1:0] OutData;
   logic              Busy;
   logic              Done;

   // Dump engine side
   modport master (
      input  Start, StartAddr, Count, RdData, WrEn, WrAddr, WrData, OutReady,
      output RdAddr, OutValid, OutAddr, OutData, Busy, Done
   );

   // Register file / consumer / controller side
   modport slave (
      output Start, StartAddr, Count, RdData, WrEn, WrAddr, WrData, OutReady,
      input  RdAddr, OutValid, OutAddr, OutData, Busy, Done
   );
endinterface

// File: rtl/reg_file_dump.sv
// Walks a range of register-file addresses and streams each captured value out.
// Latency: Start to first OutValid 2 cycles; peak 1 word per 2 cycles.
// Backpressure: a held word stays frozen until OutReady; the walk stalls meanwhile.
module reg_file_dump #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int FWD_EN = 1
) (
   input  logic           Clk,
   input  logic           Rst,
   reg_file_dump_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              done_q, done_d;
   logic [5:0]        rem_q, rem_d;

   logic [5:0]        count_eff;
   logic              fwd;

   // 0 and anything above 32 both mean a full sweep of the file
   assign count_eff = ((bus.Count == 6'd0) || (bus.Count > 6'd32)) ? 6'd32 : bus.Count;

   // A write landing on the register being sampled this edge wins; r0 is hardwired in the array
   assign fwd = (FWD_EN != 0) && bus.WrEn && (bus.WrAddr == rd_addr_q) &&
                (rd_addr_q != '0);

   // State and datapath registers; reset aborts any dump without a Done pulse
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= S_IDLE;
         rd_addr_q   <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         rem_q       <= 6'd0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         rem_q       <= rem_d;
      end
   end

   // Next-state: Start only honoured when idle, so a Start while busy is dropped
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.Start) state_d = S_FETCH;
         S_FETCH: state_d = S_HOLD;
         S_HOLD:  if (bus.OutReady) state_d = (rem_q == 6'd1) ? S_IDLE : S_FETCH;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath updates per state; the held word is never refreshed by later writes
   always_comb begin
      rd_addr_d   = rd_addr_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      rem_d       = rem_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               rd_addr_d = bus.StartAddr;
               rem_d     = count_eff;
            end
         end
         S_FETCH: begin
            out_data_d  = fwd ? bus.WrData : bus.RdData;
            out_addr_d  = rd_addr_q;
            out_valid_d = 1'b1;
         end
         S_HOLD: begin
            if (bus.OutReady) begin
               out_valid_d = 1'b0;
               if (rem_q == 6'd1) begin
                  done_d = 1'b1;
               end else begin
                  rem_d     = rem_q - 6'd1;
                  rd_addr_d = rd_addr_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.RdAddr   = rd_addr_q;
   assign bus.OutAddr  = out_addr_q;
   assign bus.OutData  = out_data_q;
   assign bus.OutValid = out_valid_q;
   assign bus.Done     = done_q;
   assign bus.Busy     = (state_q != S_IDLE);

endmodule
